// File: rtl/ccd_timing_gen_pkg.sv
// Shared types and constants for the CCD/ADC timing generator.
// Mode/state encodings, register map and register reset defaults.
package ccd_timing_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADC = 2'd0,
    MODE_CCD = 2'd1,
    MODE_PER = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam logic [2:0] A_PERIOD    = 3'd0;
  localparam logic [2:0] A_SHP_FALL  = 3'd1;
  localparam logic [2:0] A_SHP_RISE  = 3'd2;
  localparam logic [2:0] A_SHD_FALL  = 3'd3;
  localparam logic [2:0] A_SHD_RISE  = 3'd4;
  localparam logic [2:0] A_LINE_LEN  = 3'd5;
  localparam logic [2:0] A_CLAMP_LEN = 3'd6;
  localparam logic [2:0] A_FRAME     = 3'd7;

  localparam logic [15:0] RST_PERIOD    = 16'd8;
  localparam logic [15:0] RST_SHP_FALL  = 16'd1;
  localparam logic [15:0] RST_SHP_RISE  = 16'd3;
  localparam logic [15:0] RST_SHD_FALL  = 16'd5;
  localparam logic [15:0] RST_SHD_RISE  = 16'd7;
  localparam logic [15:0] RST_LINE_LEN  = 16'd256;
  localparam logic [15:0] RST_CLAMP_LEN = 16'd10;
  localparam logic [15:0] RST_FRAME     = 16'd1;

  localparam logic [15:0] MIN_PERIOD    = 16'd4;

  function automatic logic is_stream(mode_e m);
    return (m == MODE_ADC) || (m == MODE_CCD);
  endfunction

endpackage

// File: rtl/ccd_pix_counter.sv
// Pixel timing cascade: intra-pixel counter, pixel-in-line, line-in-frame.
// Held at zero while clr_i is high; advances only when en_i is high.
module ccd_pix_counter #(
  parameter int CNT_W  = 9,
  parameter int LINE_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [LINE_W-1:0] line_len_i,
  input  logic [LINE_W-1:0] frame_lines_i,
  output logic [CNT_W-1:0]  inner_o,
  output logic [LINE_W-1:0] pix_o,
  output logic [LINE_W-1:0] line_o,
  output logic              inner_wrap_o
);

  logic [CNT_W-1:0]  inner_q, inner_d;
  logic [LINE_W-1:0] pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              pix_wrap, line_wrap;

  assign inner_wrap_o = inner_q == period_i - CNT_W'(1);
  assign pix_wrap     = pix_q == line_len_i - LINE_W'(1);
  assign line_wrap    = line_q == frame_lines_i - LINE_W'(1);

  always_comb begin
    inner_d = inner_q;
    pix_d   = pix_q;
    line_d  = line_q;
    if (clr_i) begin
      inner_d = '0;
      pix_d   = '0;
      line_d  = '0;
    end else if (en_i) begin
      inner_d = inner_wrap_o ? '0 : inner_q + CNT_W'(1);
      if (inner_wrap_o) begin
        pix_d = pix_wrap ? '0 : pix_q + LINE_W'(1);
        if (pix_wrap)
          line_d = line_wrap ? '0 : line_q + LINE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inner_q <= '0;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      inner_q <= inner_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
    end
  end

  assign inner_o = inner_q;
  assign pix_o   = pix_q;
  assign line_o  = line_q;

endmodule

// File: rtl/ccd_timing_gen.sv
// CCD/ADC stimulus generator: streams samples to the DAC and drives
// CLK/SHP/SHD/HD/VD/clamp timing from programmable registers.
module ccd_timing_gen
  import ccd_timing_gen_pkg::*;
#(
  parameter int DAC_W  = 14,
  parameter int CNT_W  = 9,
  parameter int LINE_W = 10
) (
  input  logic             dds_clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [15:0]      cfg_data,
  input  logic [DAC_W-1:0] black_level,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DAC_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_fpga,
  output logic             shp_fpga,
  output logic             shd_fpga,
  output logic             hd_fpga,
  output logic             vd_fpga,
  output logic             clpdm_fpga,
  output logic             clpob_fpga,
  output logic             busy,
  output logic             underrun
);

  state_e            state_q;
  mode_e             mode_q;
  logic [CNT_W-1:0]  per_q, per_eff, half, inner;
  logic [15:0]       shp_f_q, shp_r_q, shd_f_q, shd_r_q, in16;
  logic [LINE_W-1:0] llen_q, clen_q, flines_q, pix, line_cnt;
  logic              inner_wrap, busy_w, act, stream, smp, clamp_hit;
  logic [DAC_W-1:0]  dac_q;
  logic              clk_q, shp_q, shd_q, hd_q, vd_q, clp_q, unr_q;

  always_ff @(posedge dds_clk or posedge rst) begin
    if (rst) begin
      per_q    <= RST_PERIOD[CNT_W-1:0];
      shp_f_q  <= RST_SHP_FALL;
      shp_r_q  <= RST_SHP_RISE;
      shd_f_q  <= RST_SHD_FALL;
      shd_r_q  <= RST_SHD_RISE;
      llen_q   <= RST_LINE_LEN[LINE_W-1:0];
      clen_q   <= RST_CLAMP_LEN[LINE_W-1:0];
      flines_q <= RST_FRAME[LINE_W-1:0];
    end else if (cfg_wr && state_q == ST_IDLE) begin
      unique case (cfg_addr)
        A_PERIOD:    per_q    <= cfg_data[CNT_W-1:0];
        A_SHP_FALL:  shp_f_q  <= cfg_data;
        A_SHP_RISE:  shp_r_q  <= cfg_data;
        A_SHD_FALL:  shd_f_q  <= cfg_data;
        A_SHD_RISE:  shd_r_q  <= cfg_data;
        A_LINE_LEN:  llen_q   <= cfg_data[LINE_W-1:0];
        A_CLAMP_LEN: clen_q   <= cfg_data[LINE_W-1:0];
        A_FRAME:     flines_q <= cfg_data[LINE_W-1:0];
      endcase
    end
  end

  // Period is forced even and at least 4 so HALF always splits it evenly.
  assign per_eff = (per_q < MIN_PERIOD[CNT_W-1:0])
                 ? MIN_PERIOD[CNT_W-1:0]
                 : {per_q[CNT_W-1:1], 1'b0};
  assign half    = per_eff >> 1;

  assign busy_w = state_q != ST_IDLE;

  ccd_pix_counter #(
    .CNT_W  (CNT_W),
    .LINE_W (LINE_W)
  ) u_cnt (
    .clk_i         (dds_clk),
    .rst_i         (rst),
    .clr_i         (state_q == ST_IDLE),
    .en_i          (busy_w),
    .period_i      (per_eff),
    .line_len_i    (llen_q),
    .frame_lines_i (flines_q),
    .inner_o       (inner),
    .pix_o         (pix),
    .line_o        (line_cnt),
    .inner_wrap_o  (inner_wrap)
  );

  assign in16      = 16'(inner);
  assign stream    = is_stream(mode_q);
  assign smp       = busy_w && stream && inner == half;
  assign act       = busy_w && !(state_q == ST_DRAIN && inner_wrap);
  assign clamp_hit = (clen_q >= llen_q) || (pix >= llen_q - clen_q);

  always_ff @(posedge dds_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADC;
      dac_q   <= '0;
      clk_q   <= 1'b0;
      shp_q   <= 1'b1;
      shd_q   <= 1'b1;
      hd_q    <= 1'b1;
      vd_q    <= 1'b1;
      clp_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          mode_q  <= mode_e'(mode);
          unr_q   <= 1'b0;
        end
        ST_RUN:   if (stop) state_q <= ST_DRAIN;
        ST_DRAIN: if (inner_wrap) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      // Pixel-phase outputs drop to idle levels as the last pixel ends.
      if (act) begin
        if (inner == '0)      clk_q <= 1'b1;
        else if (inner == half) clk_q <= 1'b0;
        if (in16 == shp_f_q)      shp_q <= 1'b0;
        else if (in16 == shp_r_q) shp_q <= 1'b1;
        if (in16 == shd_f_q)      shd_q <= 1'b0;
        else if (in16 == shd_r_q) shd_q <= 1'b1;
        hd_q  <= pix != '0;
        vd_q  <= !(pix == '0 && line_cnt == '0);
        clp_q <= clamp_hit;
      end else begin
        clk_q <= 1'b0;
        shp_q <= 1'b1;
        shd_q <= 1'b1;
        hd_q  <= 1'b1;
        vd_q  <= 1'b1;
        clp_q <= 1'b0;
      end

      if (busy_w) begin
        if (!stream) begin
          dac_q <= black_level;
        end else if (smp) begin
          dac_q <= s_valid ? s_data : black_level;
          if (!s_valid) unr_q <= 1'b1;
        end else if (mode_q == MODE_ADC && inner == '0) begin
          dac_q <= black_level;
        end
      end
    end
  end

  assign s_ready    = smp && s_valid;
  assign dac_d      = dac_q;
  assign clk_fpga   = clk_q;
  assign shp_fpga   = shp_q;
  assign shd_fpga   = shd_q;
  assign hd_fpga    = hd_q;
  assign vd_fpga    = vd_q;
  assign clpdm_fpga = clp_q;
  assign clpob_fpga = clp_q;
  assign busy       = busy_w;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Directed bench for ccd_timing_gen: pixel timing, stream handshake,
// period clamping, line/frame strobes, drain and async reset.
module tb_ccd_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [13:0] black;
  logic        start, stop;
  logic [1:0]  mode;
  logic [13:0] s_data;
  logic        s_valid, s_ready;
  logic [13:0] dac_d;
  logic        clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga;
  logic        clpdm_fpga, clpob_fpga, busy, underrun;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  ccd_timing_gen dut (
    .dds_clk     (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .black_level (black),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .dac_d       (dac_d),
    .clk_fpga    (clk_fpga),
    .shp_fpga    (shp_fpga),
    .shd_fpga    (shd_fpga),
    .hd_fpga     (hd_fpga),
    .vd_fpga     (vd_fpga),
    .clpdm_fpga  (clpdm_fpga),
    .clpob_fpga  (clpob_fpga),
    .busy        (busy),
    .underrun    (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic go(input logic [1:0] md);
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic stp();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle();
  endtask

  task automatic meas(output int per);
    int   r0;
    logic prev;
    r0  = -1;
    per = -1;
    for (int i = 0; i < 64; i++) begin
      prev = clk_fpga;
      tick();
      if (!prev && clk_fpga) begin
        if (r0 < 0) r0 = i;
        else begin
          per = i - r0;
          break;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, p, per;
    int hd_lo, vd_lo, dm_hi, ob_hi, shd_lo, rdy_n;
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    black = 14'd50; start = 1'b0; stop = 1'b0; mode = 2'd0;
    s_data = 14'd100; s_valid = 1'b0;
    tick();
    tick();
    chk("rst_flags", {clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga,
        clpdm_fpga, clpob_fpga, busy, underrun, s_ready}, 10'b0111100000);
    chk("rst_dac", dac_d, 0);
    rst = 1'b0;
    tick();

    // plain ADC mode, default timing
    s_valid = 1'b1;
    s_data  = 14'd100;
    go(2'd0);
    for (int m = 1; m <= 24; m++) begin
      tick();
      start  = (m == 6);
      s_data = 14'(100 + m / 8);
      #1;
      j = (m - 1) % 8;
      p = (m - 1) / 8;
      chk("t1_clk", clk_fpga, j < 4);
      chk("t1_shp", shp_fpga, !(j == 1 || j == 2));
      chk("t1_shd", shd_fpga, !(j == 5 || j == 6));
      chk("t1_dac", dac_d, (j < 4) ? 50 : 100 + p);
      chk("t1_rdy", s_ready, (m % 8) == 4);
      chk("t1_busy", busy, 1);
    end
    chk("t1_clp", clpdm_fpga, 0);
    stp();

    // period programming
    wr(3'd0, 16'd5);
    go(2'd2);
    meas(per);
    chk("p5", per, 4);
    stp();
    wr(3'd0, 16'd3);
    go(2'd2);
    meas(per);
    chk("p3", per, 4);
    wr(3'd0, 16'd12);
    stp();
    go(2'd2);
    meas(per);
    chk("p_run_wr", per, 4);
    stp();
    wr(3'd0, 16'd7);
    go(2'd2);
    meas(per);
    chk("p7", per, 6);
    stp();
    cfg_addr = 3'd0; cfg_data = 16'd8; cfg_wr = 1'b1;
    mode = 2'd2; start = 1'b1;
    tick();
    cfg_wr = 1'b0; start = 1'b0;
    meas(per);
    chk("p8_start", per, 8);
    stp();

    // CCD mode with one missing sample
    s_valid = 1'b1;
    s_data  = 14'd500;
    go(2'd1);
    chk("t3_unr0", underrun, 0);
    for (int m = 1; m <= 24; m++) begin
      tick();
      s_valid = (m != 12);
      s_data  = (m < 12) ? 14'd500 : 14'd600;
      #1;
      if (m == 4)  chk("t3_rdy0", s_ready, 1);
      if (m == 5)  chk("t3_dac0", dac_d, 500);
      if (m == 12) chk("t3_hold", dac_d, 500);
      if (m == 12) chk("t3_rdy1", s_ready, 0);
      if (m == 12) chk("t3_unr1", underrun, 0);
      if (m == 13) chk("t3_dac1", dac_d, 50);
      if (m == 13) chk("t3_unr2", underrun, 1);
      if (m == 20) chk("t3_rdy2", s_ready, 1);
      if (m == 21) chk("t3_dac2", dac_d, 600);
      if (m == 24) chk("t3_unr3", underrun, 1);
    end
    stp();
    chk("t3_unr_idle", underrun, 1);
    go(2'd1);
    chk("t3_unr_clr", underrun, 0);
    stp();

    // line / frame strobes and clamp window, periodic mode
    wr(3'd0, 16'd4);
    wr(3'd5, 16'd16);
    wr(3'd6, 16'd4);
    wr(3'd7, 16'd2);
    hd_lo = 0; vd_lo = 0; dm_hi = 0; ob_hi = 0; shd_lo = 0; rdy_n = 0;
    go(2'd2);
    for (int m = 1; m <= 128; m++) begin
      tick();
      if (!hd_fpga)   hd_lo++;
      if (!vd_fpga)   vd_lo++;
      if (clpdm_fpga) dm_hi++;
      if (clpob_fpga) ob_hi++;
      if (!shd_fpga)  shd_lo++;
      if (s_ready)    rdy_n++;
      if (m == 1)  chk("t4_hd_first", hd_fpga, 0);
      if (m == 48) chk("t4_clp_pre", clpdm_fpga, 0);
      if (m == 49) chk("t4_clp_on", clpdm_fpga, 1);
    end
    chk("t4_hd_lo", hd_lo, 8);
    chk("t4_vd_lo", vd_lo, 4);
    chk("t4_dm_hi", dm_hi, 32);
    chk("t4_ob_hi", ob_hi, 32);
    chk("t4_shd_none", shd_lo, 0);
    chk("t4_no_rdy", rdy_n, 0);
    chk("t4_dac", dac_d, 50);
    stp();
    wr(3'd6, 16'd16);
    go(2'd2);
    tick();
    tick();
    tick();
    chk("t4_clp_all_dm", clpdm_fpga, 1);
    chk("t4_clp_all_ob", clpob_fpga, 1);

    // asynchronous reset in the middle of a run
    rst = 1'b1;
    #1;
    chk("rst_run_flags", {clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga,
        clpdm_fpga, clpob_fpga, busy, underrun, s_ready}, 10'b0111100000);
    chk("rst_run_dac", dac_d, 0);
    tick();
    rst = 1'b0;
    tick();

    // default timing after reset, stop at inner 2
    s_valid = 1'b1;
    s_data  = 14'd100;
    go(2'd0);
    for (int m = 1; m <= 16; m++) begin
      tick();
      stop = (m == 10);
      #1;
      if (m == 3)  chk("t5_shp", shp_fpga, 0);
      if (m == 4)  chk("t5_rdy", s_ready, 1);
      if (m == 5)  chk("t5_dac", dac_d, 100);
      if (m == 7)  chk("t5_shd", shd_fpga, 0);
      if (m == 15) chk("t5_busy_drain", busy, 1);
      if (m == 16) begin
        chk("t5_busy_end", busy, 0);
        chk("t5_shp_end", shp_fpga, 1);
        chk("t5_shd_end", shd_fpga, 1);
        chk("t5_hd_end", hd_fpga, 1);
        chk("t5_clk_end", clk_fpga, 0);
      end
    end
    stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
